// File: rtl/axi_cache_bridge_if.sv
// AXI3 master bus (32-bit data, 4-bit ids) between the cache bridge and the crossbar.
interface axi_cache_bridge_if;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [1:0]  awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/axi_cache_bridge.sv
// I/D cache to AXI3 bridge: one outstanding read per cache port, concurrent AW/W writes.
// Optional RAW line hazard check enabled by defining AXI_BRIDGE_RAW_CHECK_EN.
module axi_cache_bridge_rd_lane #(
   parameter int LINE_WORDS = 4,
   parameter int CW         = 2
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        accept,
   input  logic                        beat,
   input  logic                        last,
   input  logic [31:0]                 rdata,
   output logic                        busy,
   output logic                        ret_valid,
   output logic [LINE_WORDS-1:0][31:0] line
);
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         busy      <= 1'b0;
         ret_valid <= 1'b0;
         cnt       <= '0;
         line      <= '0;
      end else begin
         ret_valid <= beat && last;
         if (beat) begin
            line[cnt] <= rdata;
            if (last) begin
               cnt  <= '0;
               busy <= 1'b0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
         if (accept) busy <= 1'b1;
      end
   end
endmodule

module axi_cache_bridge #(
   parameter int LINE_WORDS = 4,
   localparam int LW        = 32*LINE_WORDS
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            inst_rd_req,
   input  logic [2:0]      inst_rd_type,
   input  logic [31:0]     inst_rd_addr,
   output logic            inst_rd_rdy,
   output logic            inst_ret_valid,
   output logic [LW-1:0]   inst_ret_data,
   input  logic            data_rd_req,
   input  logic [2:0]      data_rd_type,
   input  logic [31:0]     data_rd_addr,
   input  logic [2:0]      data_rd_size,
   output logic            data_rd_rdy,
   output logic            data_ret_valid,
   output logic [LW-1:0]   data_ret_data,
   input  logic            data_wr_req,
   input  logic [2:0]      data_wr_type,
   input  logic [31:0]     data_wr_addr,
   input  logic [2:0]      data_wr_size,
   input  logic [3:0]      data_wr_wstrb,
   input  logic [LW-1:0]   data_wr_data,
   output logic            data_wr_rdy,
   output logic            data_wr_ok,
   axi_cache_bridge_if.master axi
);
   localparam int         CW       = $clog2(LINE_WORDS);
   localparam int         L        = $clog2(4*LINE_WORDS);
   localparam logic [7:0] LEN_LINE = 8'(LINE_WORDS-1);
   localparam logic [2:0] T_LINE   = 3'b100;

   typedef enum logic       {AR_IDLE, AR_SEND} ar_state_t;
   typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

   ar_state_t ar_state, ar_next;
   w_state_t  w_state, w_next;

   logic [1:0] busy, ret_v, rd_acc, beat;
   logic [1:0][LINE_WORDS-1:0][31:0] lines;
   logic inst_acc, data_acc, wr_acc, raw_block;

   logic        ar_id;
   logic [31:0] ar_addr;
   logic [7:0]  ar_len;
   logic [2:0]  ar_size;

   logic [31:0] w_addr;
   logic [7:0]  w_len;
   logic [2:0]  w_size;
   logic [3:0]  w_strb;
   logic [LINE_WORDS-1:0][31:0] w_line;
   logic [CW-1:0] wcnt;
   logic aw_pend, w_pend, w_last, wr_ok;

   // ---------------- read request channel ----------------
   assign data_rd_rdy = resetn && (ar_state == AR_IDLE) && !busy[1] && !raw_block;
   assign data_acc    = data_rd_req && data_rd_rdy;
   // data has priority; inst is held off in any cycle data is taken
   assign inst_rd_rdy = resetn && (ar_state == AR_IDLE) && !busy[0] && !data_acc;
   assign inst_acc    = inst_rd_req && inst_rd_rdy;
   assign rd_acc      = {data_acc, inst_acc};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) ar_state <= AR_IDLE;
      else         ar_state <= ar_next;
   end

   always_comb begin
      ar_next = ar_state;
      case (ar_state)
         AR_IDLE: if (data_acc || inst_acc) ar_next = AR_SEND;
         AR_SEND: if (axi.arready)          ar_next = AR_IDLE;
         default: ar_next = AR_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ar_id   <= 1'b0;
         ar_addr <= '0;
         ar_len  <= '0;
         ar_size <= '0;
      end else if (data_acc) begin
         ar_id   <= 1'b1;
         ar_addr <= data_rd_addr;
         ar_len  <= (data_rd_type == T_LINE) ? LEN_LINE : 8'd0;
         ar_size <= (data_rd_type == T_LINE) ? 3'd2 : data_rd_size;
      end else if (inst_acc) begin
         ar_id   <= 1'b0;
         ar_addr <= inst_rd_addr;
         ar_len  <= (inst_rd_type == T_LINE) ? LEN_LINE : 8'd0;
         ar_size <= 3'd2;
      end
   end

   assign axi.arid    = {3'b000, ar_id};
   assign axi.araddr  = ar_addr;
   assign axi.arlen   = ar_len;
   assign axi.arsize  = ar_size;
   assign axi.arburst = 2'b01;
   assign axi.arlock  = 2'b00;
   assign axi.arcache = 4'h0;
   assign axi.arprot  = 3'b000;
   assign axi.arvalid = (ar_state == AR_SEND);

   // ---------------- read data channel ----------------
   assign axi.rready = resetn;

   for (genvar i = 0; i < 2; i++) begin : g_lane
      assign beat[i] = axi.rvalid && axi.rready && (axi.rid[0] == (i == 1));
      axi_cache_bridge_rd_lane #(.LINE_WORDS(LINE_WORDS), .CW(CW)) u_lane (
         .clk       (clk),
         .resetn    (resetn),
         .accept    (rd_acc[i]),
         .beat      (beat[i]),
         .last      (axi.rlast),
         .rdata     (axi.rdata),
         .busy      (busy[i]),
         .ret_valid (ret_v[i]),
         .line      (lines[i])
      );
   end

   assign inst_ret_valid = ret_v[0];
   assign data_ret_valid = ret_v[1];
   assign inst_ret_data  = lines[0];
   assign data_ret_data  = lines[1];

   // ---------------- write channel ----------------
   assign data_wr_rdy = resetn && (w_state == W_IDLE);
   assign wr_acc      = data_wr_req && data_wr_rdy;
   assign w_last      = (8'(wcnt) == w_len);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) w_state <= W_IDLE;
      else         w_state <= w_next;
   end

   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE: if (wr_acc) w_next = W_SEND;
         // AW and last W may finish in either order or together
         W_SEND: if ((!aw_pend || axi.awready) && (!w_pend || (axi.wready && w_last)))
                    w_next = W_RESP;
         W_RESP: if (axi.bvalid) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         w_addr  <= '0;
         w_len   <= '0;
         w_size  <= '0;
         w_strb  <= '0;
         w_line  <= '0;
         wcnt    <= '0;
         aw_pend <= 1'b0;
         w_pend  <= 1'b0;
         wr_ok   <= 1'b0;
      end else begin
         wr_ok <= (w_state == W_RESP) && axi.bvalid;
         if (wr_acc) begin
            w_addr  <= data_wr_addr;
            w_line  <= data_wr_data;
            wcnt    <= '0;
            aw_pend <= 1'b1;
            w_pend  <= 1'b1;
            w_len   <= (data_wr_type == T_LINE) ? LEN_LINE : 8'd0;
            w_size  <= (data_wr_type == T_LINE) ? 3'd2 : data_wr_size;
            w_strb  <= (data_wr_type == T_LINE) ? 4'hF : data_wr_wstrb;
         end else begin
            if (aw_pend && axi.awready) aw_pend <= 1'b0;
            if (w_pend && axi.wready) begin
               if (w_last) w_pend <= 1'b0;
               else        wcnt   <= wcnt + 1'b1;
            end
         end
      end
   end

   assign axi.awid    = 4'd1;
   assign axi.awaddr  = w_addr;
   assign axi.awlen   = w_len;
   assign axi.awsize  = w_size;
   assign axi.awburst = 2'b01;
   assign axi.awlock  = 2'b00;
   assign axi.awcache = 4'h0;
   assign axi.awprot  = 3'b000;
   assign axi.awvalid = aw_pend;
   assign axi.wid     = 4'd1;
   assign axi.wdata   = w_line[wcnt];
   assign axi.wstrb   = w_strb;
   assign axi.wlast   = w_pend && w_last;
   assign axi.wvalid  = w_pend;
   assign axi.bready  = (w_state == W_RESP);
   assign data_wr_ok  = wr_ok;

   // ---------------- read-after-write hazard ----------------
`ifdef AXI_BRIDGE_RAW_CHECK_EN
   logic [31-L:0] wr_line_addr;
   // while idle the incoming write's line is the one to compare against
   assign wr_line_addr = (w_state == W_IDLE) ? data_wr_addr[31:L] : w_addr[31:L];
   assign raw_block    = ((w_state != W_IDLE) || wr_acc) && (data_rd_addr[31:L] == wr_line_addr);
`else
   assign raw_block = 1'b0;
`endif

   logic unused_ok;
   assign unused_ok = ^{axi.rid[3:1], axi.rresp, axi.bid, axi.bresp};
endmodule

// File: tb/tb_axi_cache_bridge.sv
// Directed bench for axi_cache_bridge (LINE_WORDS=4) with a hand-driven AXI slave.
module tb_axi_cache_bridge;
   localparam int LINE_WORDS = 4;
   localparam int LW = 32*LINE_WORDS;
   localparam logic [2:0] T_WORD = 3'b010;
   localparam logic [2:0] T_LINE = 3'b100;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic inst_rd_req = 1'b0;
   logic [2:0] inst_rd_type = '0;
   logic [31:0] inst_rd_addr = '0;
   logic inst_rd_rdy, inst_ret_valid;
   logic [LW-1:0] inst_ret_data;
   logic data_rd_req = 1'b0;
   logic [2:0] data_rd_type = '0;
   logic [31:0] data_rd_addr = '0;
   logic [2:0] data_rd_size = '0;
   logic data_rd_rdy, data_ret_valid;
   logic [LW-1:0] data_ret_data;
   logic data_wr_req = 1'b0;
   logic [2:0] data_wr_type = '0;
   logic [31:0] data_wr_addr = '0;
   logic [2:0] data_wr_size = '0;
   logic [3:0] data_wr_wstrb = '0;
   logic [LW-1:0] data_wr_data = '0;
   logic data_wr_rdy, data_wr_ok;

   int n_chk = 0;
   int n_pass = 0;
`ifdef AXI_BRIDGE_RAW_CHECK_EN
   localparam logic RAW_EN = 1'b1;
`else
   localparam logic RAW_EN = 1'b0;
`endif
   logic raw_exp;

   axi_cache_bridge_if axi();

   axi_cache_bridge #(.LINE_WORDS(LINE_WORDS)) dut (
      .clk(clk), .resetn(resetn),
      .inst_rd_req(inst_rd_req), .inst_rd_type(inst_rd_type), .inst_rd_addr(inst_rd_addr),
      .inst_rd_rdy(inst_rd_rdy), .inst_ret_valid(inst_ret_valid), .inst_ret_data(inst_ret_data),
      .data_rd_req(data_rd_req), .data_rd_type(data_rd_type), .data_rd_addr(data_rd_addr),
      .data_rd_size(data_rd_size), .data_rd_rdy(data_rd_rdy), .data_ret_valid(data_ret_valid),
      .data_ret_data(data_ret_data),
      .data_wr_req(data_wr_req), .data_wr_type(data_wr_type), .data_wr_addr(data_wr_addr),
      .data_wr_size(data_wr_size), .data_wr_wstrb(data_wr_wstrb), .data_wr_data(data_wr_data),
      .data_wr_rdy(data_wr_rdy), .data_wr_ok(data_wr_ok),
      .axi(axi)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic r_beat(input logic [3:0] id, input logic [31:0] d, input logic last);
      axi.rvalid = 1'b1; axi.rid = id; axi.rdata = d; axi.rlast = last;
      tick();
      axi.rvalid = 1'b0; axi.rlast = 1'b0;
   endtask

   task automatic ar_hs();
      axi.arready = 1'b1; tick(); axi.arready = 1'b0;
   endtask

   initial begin
      axi.arready = 0; axi.rvalid = 0; axi.rid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 0;
      axi.awready = 0; axi.wready = 0; axi.bid = 4'd1; axi.bresp = 0; axi.bvalid = 0;
      raw_exp = RAW_EN;

      // reset state
      #2;
      chk("rst_inst_rdy", inst_rd_rdy, 0);
      chk("rst_data_rdy", data_rd_rdy, 0);
      chk("rst_wr_rdy", data_wr_rdy, 0);
      chk("rst_arvalid", axi.arvalid, 0);
      chk("rst_awvalid", axi.awvalid, 0);
      chk("rst_wlast", axi.wlast, 0);
      tick(); tick();
      resetn = 1'b1; #1;
      chk("rel_rdy", {inst_rd_rdy, data_rd_rdy, data_wr_rdy}, 3'b111);

      // single inst line read
      inst_rd_req = 1; inst_rd_type = T_LINE; inst_rd_addr = 32'h1fc0_0000;
      tick(); inst_rd_req = 0;
      chk("t1_arvalid", axi.arvalid, 1);
      chk("t1_arid", axi.arid, 0);
      chk("t1_arlen", axi.arlen, 3);
      chk("t1_arsize", axi.arsize, 2);
      chk("t1_araddr", axi.araddr, 32'h1fc0_0000);
      ar_hs();
      chk("t1_arvalid_drop", axi.arvalid, 0);
      chk("t1_inst_busy", inst_rd_rdy, 0);
      chk("t1_data_free", data_rd_rdy, 1);
      r_beat(0, 32'h11, 0); r_beat(0, 32'h22, 0); r_beat(0, 32'h33, 0);
      chk("t1_no_early_ret", inst_ret_valid, 0);
      r_beat(0, 32'h44, 1);
      chk("t1_ret_valid", inst_ret_valid, 1);
      chk("t1_ret_data", inst_ret_data, 128'h00000044_00000033_00000022_00000011);
      chk("t1_rdy_in_ret", inst_rd_rdy, 1);
      tick();
      chk("t1_ret_pulse", inst_ret_valid, 0);
      chk("t1_ret_hold", inst_ret_data, 128'h00000044_00000033_00000022_00000011);

      // simultaneous inst and data line reads, interleaved beats
      inst_rd_req = 1; inst_rd_type = T_LINE; inst_rd_addr = 32'h0000_0100;
      data_rd_req = 1; data_rd_type = T_LINE; data_rd_addr = 32'h0000_0200;
      #1;
      chk("t2_data_rdy", data_rd_rdy, 1);
      chk("t2_inst_held", inst_rd_rdy, 0);
      tick(); data_rd_req = 0;
      chk("t2_arid_data", axi.arid, 1);
      chk("t2_araddr_data", axi.araddr, 32'h0000_0200);
      ar_hs();
      chk("t2_inst_rdy", inst_rd_rdy, 1);
      tick(); inst_rd_req = 0;
      chk("t2_arid_inst", axi.arid, 0);
      chk("t2_araddr_inst", axi.araddr, 32'h0000_0100);
      ar_hs();
      r_beat(1, 32'hA1, 0); r_beat(0, 32'hB1, 0);
      r_beat(1, 32'hA2, 0); r_beat(0, 32'hB2, 0);
      r_beat(1, 32'hA3, 0); r_beat(0, 32'hB3, 0);
      r_beat(1, 32'hA4, 1);
      chk("t2_data_ret", {data_ret_valid, inst_ret_valid}, 2'b10);
      chk("t2_data_line", data_ret_data, 128'h000000A4_000000A3_000000A2_000000A1);
      r_beat(0, 32'hB4, 1);
      chk("t2_inst_ret", {data_ret_valid, inst_ret_valid}, 2'b01);
      chk("t2_inst_line", inst_ret_data, 128'h000000B4_000000B3_000000B2_000000B1);

      // single data read, size 1: only word 0 updates
      data_rd_req = 1; data_rd_type = T_WORD; data_rd_size = 3'd1; data_rd_addr = 32'h0000_0302;
      tick(); data_rd_req = 0;
      chk("t3_arlen", axi.arlen, 0);
      chk("t3_arsize", axi.arsize, 1);
      ar_hs();
      r_beat(1, 32'h55, 1);
      chk("t3_ret", data_ret_valid, 1);
      chk("t3_line", data_ret_data, 128'h000000A4_000000A3_000000A2_00000055);

      // line write, W completes before AW, RAW probes while pending
      axi.wready = 1; axi.awready = 0;
      data_wr_req = 1; data_wr_type = T_LINE; data_wr_addr = 32'h8000_0010; data_wr_wstrb = 4'h0;
      data_wr_data = 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0;
      data_rd_addr = 32'h8000_001c;
      #1;
      chk("t4_raw_on_accept", data_rd_rdy, !raw_exp);
      tick(); data_wr_req = 0;
      chk("t4_valids", {axi.awvalid, axi.wvalid}, 2'b11);
      chk("t4_awlen", axi.awlen, 3);
      chk("t4_wstrb", axi.wstrb, 4'hF);
      chk("t4_w0", {axi.wdata, axi.wlast}, {32'hD0D0D0D0, 1'b0});
      chk("t4_raw_same", data_rd_rdy, !raw_exp);
      data_rd_addr = 32'h8000_0020; #1;
      chk("t4_raw_other", data_rd_rdy, 1);
      data_rd_addr = 32'h8000_001c;
      tick();
      chk("t4_w1", {axi.wdata, axi.wlast}, {32'hD1D1D1D1, 1'b0});
      tick();
      chk("t4_w2", {axi.wdata, axi.wlast}, {32'hD2D2D2D2, 1'b0});
      tick();
      chk("t4_w3", {axi.wdata, axi.wlast}, {32'hD3D3D3D3, 1'b1});
      tick();
      chk("t4_w_done", {axi.awvalid, axi.wvalid, axi.bready}, 3'b100);
      axi.awready = 1; tick(); axi.awready = 0;
      chk("t4_aw_done", {axi.awvalid, axi.bready}, 2'b01);
      axi.bvalid = 1; #1;
      chk("t4_raw_in_b", data_rd_rdy, !raw_exp);
      tick(); axi.bvalid = 0;
      chk("t4_wr_ok", {data_wr_ok, data_wr_rdy, axi.bready}, 3'b110);
      chk("t4_raw_clear", data_rd_rdy, 1);
      tick();
      chk("t4_wr_ok_pulse", data_wr_ok, 0);

      // single write, AW and W together
      data_wr_req = 1; data_wr_type = T_WORD; data_wr_addr = 32'h8000_0044;
      data_wr_size = 3'd1; data_wr_wstrb = 4'b0110; data_wr_data = 128'h0000CAFE;
      tick(); data_wr_req = 0;
      chk("t5_awlen", axi.awlen, 0);
      chk("t5_awsize", axi.awsize, 1);
      chk("t5_wstrb", axi.wstrb, 4'b0110);
      chk("t5_wbeat", {axi.wdata, axi.wlast}, {32'h0000CAFE, 1'b1});
      axi.awready = 1; axi.wready = 1; tick(); axi.awready = 0; axi.wready = 0;
      chk("t5_resp", {axi.awvalid, axi.wvalid, axi.bready}, 3'b001);
      axi.bvalid = 1; tick(); axi.bvalid = 0;
      chk("t5_wr_ok", data_wr_ok, 1);

      // reset mid-burst with a write hanging on AW/W
      data_wr_req = 1; data_wr_type = T_LINE; data_wr_addr = 32'h9000_0000;
      tick(); data_wr_req = 0;
      inst_rd_req = 1; inst_rd_type = T_LINE; inst_rd_addr = 32'h0000_0400;
      tick(); inst_rd_req = 0;
      ar_hs();
      r_beat(0, 32'h1, 0); r_beat(0, 32'h2, 0);
      chk("t6_pre_aw", {axi.awvalid, axi.wvalid}, 2'b11);
      resetn = 1'b0; #1;
      chk("t6_rst_valids", {axi.arvalid, axi.awvalid, axi.wvalid}, 3'b000);
      chk("t6_rst_rdy", {inst_rd_rdy, data_rd_rdy, data_wr_rdy}, 3'b000);
      chk("t6_rst_iline", inst_ret_data, 0);
      chk("t6_rst_dline", data_ret_data, 0);
      tick(); tick();
      resetn = 1'b1; #1;
      chk("t6_rel_rdy", {inst_rd_rdy, data_rd_rdy}, 2'b11);
      inst_rd_req = 1; inst_rd_type = T_LINE; inst_rd_addr = 32'h0000_0400;
      tick(); inst_rd_req = 0;
      ar_hs();
      r_beat(0, 32'h5, 0); r_beat(0, 32'h6, 0); r_beat(0, 32'h7, 0); r_beat(0, 32'h8, 1);
      chk("t6_fresh_ret", inst_ret_valid, 1);
      chk("t6_fresh_line", inst_ret_data, 128'h00000008_00000007_00000006_00000005);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
